swd_xfer_sequencer: RTL and testbench

SWD_XFER_SEQUENCER -- requirements
Module: swd_xfer_sequencer

---
 rtl/swd_seq_pkg.sv | 46 ++++
 rtl/swd_frame_engine.sv | 57 +++++
 rtl/swd_xfer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_swd_xfer_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/swd_seq_pkg.sv
// Shared constants, frame layout and FSM state type for the SWD transfer sequencer.
package swd_seq_pkg;

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REQ_W   = 8;
    localparam int unsigned ACK_W   = 3;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned GAP_W   = 8;

    localparam logic [ACK_W-1:0] ACK_OK    = 3'b001;
    localparam logic [ACK_W-1:0] ACK_WAIT  = 3'b010;
    localparam logic [ACK_W-1:0] ACK_FAULT = 3'b100;

    localparam int unsigned REQ_LO  = 2;
    localparam int unsigned TURN    = 10;
    localparam int unsigned ACK_LO  = 11;
    localparam int unsigned DATA_LO = 14;
    localparam int unsigned PAR     = 46;
    localparam int unsigned LAST    = 47;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    // Host-driven line value for frame bit cnt; zero on pad, turn, ACK, tail and read data.
    function automatic logic frame_mosi(input logic [CNT_W-1:0]  cnt,
                                        input logic [REQ_W-1:0]  req,
                                        input logic              rnw,
                                        input logic [DATA_W-1:0] wdata);
        logic bit_v;
        bit_v = 1'b0;
        if (cnt >= CNT_W'(REQ_LO) && cnt < CNT_W'(TURN)) begin
            bit_v = req[3'(cnt - CNT_W'(REQ_LO))];
        end else if (!rnw && cnt >= CNT_W'(DATA_LO) && cnt < CNT_W'(PAR)) begin
            bit_v = wdata[5'(cnt - CNT_W'(DATA_LO))];
        end else if (!rnw && cnt == CNT_W'(PAR)) begin
            bit_v = ^wdata;
        end
        return bit_v;
    endfunction

endpackage

// File: rtl/swd_frame_engine.sv
// Walks one 48-bit SWD frame: bit counter, registered host bit, ACK/DATA/parity capture.
module swd_frame_engine
    import swd_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_active,
    input  logic              i_tick,
    input  logic [REQ_W-1:0]  i_req,
    input  logic              i_rnw,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_miso,
    output logic              o_mosi,
    output logic              o_last_c,
    output logic [ACK_W-1:0]  o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_par
);

    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_mosi;
    logic [ACK_W-1:0]  r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_par;
    logic [CNT_W-1:0]  w_next_cnt;

    assign w_next_cnt = r_bit_cnt + CNT_W'(1);
    assign o_last_c   = i_active && i_tick && (r_bit_cnt == CNT_W'(LAST));
    assign o_mosi     = r_mosi;
    assign o_ack      = r_ack;
    assign o_rdata    = r_rdata;
    assign o_par      = r_par;

    // Everything is held cleared outside FRAME so each frame starts at bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n || !i_active) begin
            r_bit_cnt <= '0;
            r_mosi    <= 1'b0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_par     <= 1'b0;
        end else if (i_tick) begin
            r_bit_cnt <= w_next_cnt;
            r_mosi    <= frame_mosi(w_next_cnt, i_req, i_rnw, i_wdata);
            if (r_bit_cnt >= CNT_W'(ACK_LO) && r_bit_cnt < CNT_W'(DATA_LO)) begin
                r_ack[2'(r_bit_cnt - CNT_W'(ACK_LO))] <= i_miso;
            end
            if (i_rnw && r_bit_cnt >= CNT_W'(DATA_LO) && r_bit_cnt < CNT_W'(PAR)) begin
                r_rdata[5'(r_bit_cnt - CNT_W'(DATA_LO))] <= i_miso;
            end
            if (i_rnw && r_bit_cnt == CNT_W'(PAR)) begin
                r_par <= i_miso;
            end
        end
    end

endmodule

// File: rtl/swd_xfer_sequencer.sv
// SWD transfer sequencer: command/response handshakes, WAIT retry with idle gap, frame engine control.
module swd_xfer_sequencer
    import swd_seq_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 7,
    parameter int unsigned GAP_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_tick,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [REQ_W-1:0]    i_cmd_req,
    input  logic                i_cmd_rnw,
    input  logic [DATA_W-1:0]   i_cmd_wdata,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [ACK_W-1:0]    o_rsp_ack,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic                o_rsp_parity_err,
    output logic [RETRY_W-1:0]  o_rsp_retries,
    output logic                o_fe_rst_n,
    output logic                o_fe_rnw,
    output logic                o_fe_mosi,
    input  logic                i_fe_miso
);

    seq_state_t         r_state, w_state_nxt;
    logic [REQ_W-1:0]   r_req, w_req_nxt;
    logic               r_rnw, w_rnw_nxt;
    logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
    logic [RETRY_W-1:0] r_retries, w_retries_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic               r_cmd_ready, w_cmd_ready_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [ACK_W-1:0]   r_rsp_ack, w_rsp_ack_nxt;
    logic [DATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
    logic               r_rsp_perr, w_rsp_perr_nxt;
    logic [RETRY_W-1:0] r_rsp_retries, w_rsp_retries_nxt;
    logic               r_fe_rst_n, w_fe_rst_n_nxt;
    logic               r_fe_rnw, w_fe_rnw_nxt;

    logic               w_active;
    logic               w_last_c;
    logic [ACK_W-1:0]   w_ack;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_par;
    logic               w_read_ok;

    assign w_active  = (r_state == ST_FRAME);
    assign w_read_ok = r_rnw && (w_ack == ACK_OK);

    swd_frame_engine u_frame_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_active (w_active),
        .i_tick   (i_tick),
        .i_req    (r_req),
        .i_rnw    (r_rnw),
        .i_wdata  (r_wdata),
        .i_miso   (i_fe_miso),
        .o_mosi   (o_fe_mosi),
        .o_last_c (w_last_c),
        .o_ack    (w_ack),
        .o_rdata  (w_rdata),
        .o_par    (w_par)
    );

    // Next-state and next registered-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_req_nxt         = r_req;
        w_rnw_nxt         = r_rnw;
        w_wdata_nxt       = r_wdata;
        w_retries_nxt     = r_retries;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_ack_nxt     = r_rsp_ack;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_perr_nxt    = r_rsp_perr;
        w_rsp_retries_nxt = r_rsp_retries;
        w_fe_rst_n_nxt    = r_fe_rst_n;
        w_fe_rnw_nxt      = r_fe_rnw;

        unique case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_state_nxt     = ST_FRAME;
                    w_req_nxt       = i_cmd_req;
                    w_rnw_nxt       = i_cmd_rnw;
                    w_wdata_nxt     = i_cmd_wdata;
                    w_retries_nxt   = '0;
                    w_cmd_ready_nxt = 1'b0;
                    w_fe_rst_n_nxt  = 1'b1;
                    w_fe_rnw_nxt    = i_cmd_rnw;
                end
            end
            ST_FRAME: begin
                if (w_last_c) begin
                    w_fe_rst_n_nxt = 1'b0;
                    w_fe_rnw_nxt   = 1'b1;
                    if (w_ack == ACK_WAIT && r_retries < RETRY_W'(MAX_RETRY)) begin
                        w_state_nxt   = ST_GAP;
                        w_retries_nxt = r_retries + RETRY_W'(1);
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_state_nxt       = ST_RESP;
                        w_rsp_valid_nxt   = 1'b1;
                        w_rsp_ack_nxt     = w_ack;
                        w_rsp_rdata_nxt   = w_read_ok ? w_rdata : '0;
                        w_rsp_perr_nxt    = w_read_ok && ((^w_rdata) != w_par);
                        w_rsp_retries_nxt = r_retries;
                    end
                end
            end
            ST_GAP: begin
                if (i_tick) begin
                    if (r_gap_cnt == GAP_W'(GAP_BITS - 1)) begin
                        w_state_nxt    = ST_FRAME;
                        w_gap_cnt_nxt  = '0;
                        w_fe_rst_n_nxt = 1'b1;
                        w_fe_rnw_nxt   = r_rnw;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                    end
                end
            end
            ST_RESP: begin
                // cmd_ready stays low this cycle, so no command can slip in on the handshake.
                if (i_rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_req         <= '0;
            r_rnw         <= 1'b0;
            r_wdata       <= '0;
            r_retries     <= '0;
            r_gap_cnt     <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_ack     <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_perr    <= 1'b0;
            r_rsp_retries <= '0;
            r_fe_rst_n    <= 1'b0;
            r_fe_rnw      <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_req         <= w_req_nxt;
            r_rnw         <= w_rnw_nxt;
            r_wdata       <= w_wdata_nxt;
            r_retries     <= w_retries_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_ack     <= w_rsp_ack_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_perr    <= w_rsp_perr_nxt;
            r_rsp_retries <= w_rsp_retries_nxt;
            r_fe_rst_n    <= w_fe_rst_n_nxt;
            r_fe_rnw      <= w_fe_rnw_nxt;
        end
    end

    assign o_cmd_ready      = r_cmd_ready;
    assign o_rsp_valid      = r_rsp_valid;
    assign o_rsp_ack        = r_rsp_ack;
    assign o_rsp_rdata      = r_rsp_rdata;
    assign o_rsp_parity_err = r_rsp_perr;
    assign o_rsp_retries    = r_rsp_retries;
    assign o_fe_rst_n       = r_fe_rst_n;
    assign o_fe_rnw         = r_fe_rnw;

endmodule

// File: tb/tb_swd_xfer_sequencer.sv
// Self-checking bench: emulated SWD target plus a transaction-level model of the retry rules.
module tb_swd_xfer_sequencer;

    localparam int unsigned MAXR = 7;
    localparam int unsigned GAPB = 8;
    localparam logic [2:0] A_OK    = 3'b001;
    localparam logic [2:0] A_WAIT  = 3'b010;
    localparam logic [2:0] A_FAULT = 3'b100;
    localparam logic [2:0] A_NONE  = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        i_tick;
    logic        i_cmd_valid;
    logic [7:0]  i_cmd_req;
    logic        i_cmd_rnw;
    logic [31:0] i_cmd_wdata;
    logic        i_rsp_ready;
    logic        i_fe_miso;

    logic        o_cmd_ready, o_rsp_valid, o_rsp_parity_err, o_fe_rst_n, o_fe_rnw, o_fe_mosi;
    logic [2:0]  o_rsp_ack;
    logic [31:0] o_rsp_rdata;
    logic [3:0]  o_rsp_retries;

    logic        z_cmd_ready, z_rsp_valid, z_rsp_parity_err, z_fe_rst_n, z_fe_rnw, z_fe_mosi;
    logic [2:0]  z_rsp_ack;
    logic [31:0] z_rsp_rdata;
    logic [3:0]  z_rsp_retries;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] g_acks[$];

    swd_xfer_sequencer #(.MAX_RETRY(MAXR), .GAP_BITS(GAPB)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_req(i_cmd_req), .i_cmd_rnw(i_cmd_rnw), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_ack(o_rsp_ack), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_parity_err(o_rsp_parity_err), .o_rsp_retries(o_rsp_retries),
        .o_fe_rst_n(o_fe_rst_n), .o_fe_rnw(o_fe_rnw), .o_fe_mosi(o_fe_mosi),
        .i_fe_miso(i_fe_miso)
    );

    // Zero-retry instance in lockstep on the same inputs.
    swd_xfer_sequencer #(.MAX_RETRY(0), .GAP_BITS(3)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(z_cmd_ready),
        .i_cmd_req(i_cmd_req), .i_cmd_rnw(i_cmd_rnw), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(z_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_ack(z_rsp_ack), .o_rsp_rdata(z_rsp_rdata),
        .o_rsp_parity_err(z_rsp_parity_err), .o_rsp_retries(z_rsp_retries),
        .o_fe_rst_n(z_fe_rst_n), .o_fe_rnw(z_fe_rnw), .o_fe_mosi(z_fe_mosi),
        .i_fe_miso(i_fe_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        repeat ($urandom_range(0, 2)) step();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    function automatic logic [2:0] ack_for(input int f);
        return (f < g_acks.size()) ? g_acks[f] : g_acks[g_acks.size() - 1];
    endfunction

    // Target drives ACK at 11..13, DATA at 14..45, parity at 46; other bits are junk.
    function automatic logic target_bit(input int k, input logic [2:0] a,
                                        input logic [31:0] d, input logic p);
        if (k >= 11 && k <= 13) return a[k - 11];
        if (k >= 14 && k <= 45) return d[k - 14];
        if (k == 46) return p;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ":cmd_ready"}, 64'(o_cmd_ready), 64'd1);
        chk({tag, ":rsp_valid"}, 64'(o_rsp_valid), 64'd0);
        chk({tag, ":fe_rst_n"},  64'(o_fe_rst_n),  64'd0);
        chk({tag, ":fe_mosi"},   64'(o_fe_mosi),   64'd0);
        chk({tag, ":fe_rnw"},    64'(o_fe_rnw),    64'd1);
    endtask

    task automatic accept(input string tag, input logic [7:0] req, input logic rnw,
                          input logic [31:0] wdata);
        chk({tag, ":ready_before"}, 64'(o_cmd_ready), 64'd1);
        i_cmd_valid = 1'b1;
        i_cmd_req   = req;
        i_cmd_rnw   = rnw;
        i_cmd_wdata = wdata;
        step();
        i_cmd_valid = 1'b0;
        i_cmd_req   = 8'($urandom);
        i_cmd_wdata = $urandom;
        chk({tag, ":ready_after"}, 64'(o_cmd_ready), 64'd0);
        chk({tag, ":fe_rnw"},      64'(o_fe_rnw),    64'(rnw));
    endtask

    task automatic xfer(input string tag, input logic [7:0] req, input logic rnw,
                        input logic [31:0] wdata, input logic [31:0] tdata, input logic tpar);
        logic [47:0] exp_mosi, obs_mosi;
        logic [2:0]  a;
        logic        ok, bad;
        int          retries, f, n;
        exp_mosi       = '0;
        exp_mosi[9:2]  = req;
        if (!rnw) begin
            exp_mosi[45:14] = wdata;
            exp_mosi[46]    = ^wdata;
        end
        accept(tag, req, rnw, wdata);
        retries = 0;
        f = 0;
        a = A_OK;
        while (f < 20) begin
            a = ack_for(f);
            chk({tag, ":frame_rst_n"}, 64'(o_fe_rst_n), 64'd1);
            bad = 1'b0;
            for (int k = 0; k < 48; k++) begin
                obs_mosi[k] = o_fe_mosi;
                if (o_fe_rnw !== rnw || o_fe_rst_n !== 1'b1 || o_rsp_valid !== 1'b0) bad = 1'b1;
                i_fe_miso = target_bit(k, a, tdata, tpar);
                pulse_tick();
            end
            chk({tag, ":mosi_frame"}, 64'(obs_mosi), 64'(exp_mosi));
            chk({tag, ":frame_lines"}, 64'(bad), 64'd0);
            if (f == 0 && a == A_WAIT) begin
                chk({tag, ":z_valid"},   64'(z_rsp_valid),   64'd1);
                chk({tag, ":z_ack"},     64'(z_rsp_ack),     64'(A_WAIT));
                chk({tag, ":z_retries"}, 64'(z_rsp_retries), 64'd0);
                chk({tag, ":z_misc"}, 64'({z_rsp_rdata, z_rsp_parity_err, z_cmd_ready,
                                           z_fe_rst_n, z_fe_mosi, z_fe_rnw}), 64'd1);
            end
            if (a == A_WAIT && retries < int'(MAXR)) begin
                retries++;
                f++;
                chk({tag, ":gap_rst_n"}, 64'(o_fe_rst_n), 64'd0);
                n = 0;
                bad = 1'b0;
                while (o_fe_rst_n === 1'b0 && n < 20) begin
                    if (o_fe_mosi !== 1'b0 || o_rsp_valid !== 1'b0) bad = 1'b1;
                    pulse_tick();
                    n++;
                end
                chk({tag, ":gap_ticks"}, 64'(n), 64'(GAPB));
                chk({tag, ":gap_lines"}, 64'(bad), 64'd0);
            end else begin
                break;
            end
        end
        ok = rnw && (a == A_OK);
        for (int r = 0; r < 2; r++) begin
            chk({tag, ":rsp_valid"},   64'(o_rsp_valid),      64'd1);
            chk({tag, ":rsp_ack"},     64'(o_rsp_ack),        64'(a));
            chk({tag, ":rsp_rdata"},   64'(o_rsp_rdata),      ok ? 64'(tdata) : 64'd0);
            chk({tag, ":rsp_perr"},    64'(o_rsp_parity_err), 64'(ok && ((^tdata) != tpar)));
            chk({tag, ":rsp_retries"}, 64'(o_rsp_retries),    64'(retries));
            chk({tag, ":resp_lines"},  64'({o_cmd_ready, o_fe_rst_n, o_fe_mosi}), 64'd0);
            // Ticks and a pending command must not disturb a held response.
            i_cmd_valid = 1'b1;
            repeat (2) pulse_tick();
        end
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        i_cmd_valid = 1'b0;
        check_idle({tag, ":after_hs"});
    endtask

    initial begin
        logic [31:0] d;
        logic        bad;
        rst_n = 1'b0;
        i_tick = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_req = '0;
        i_cmd_rnw = 1'b0;
        i_cmd_wdata = '0;
        i_rsp_ready = 1'b0;
        i_fe_miso = 1'b0;
        repeat (3) step();
        chk("reset:rsp_fields", 64'({o_rsp_ack, o_rsp_rdata, o_rsp_parity_err, o_rsp_retries}), 64'd0);
        check_idle("reset");
        rst_n = 1'b1;
        step();
        check_idle("post_reset");

        g_acks = '{A_OK};
        xfer("read_a5", 8'hA5, 1'b1, 32'h0, 32'h12345678, 1'b1);

        g_acks = '{A_WAIT, A_WAIT, A_OK};
        xfer("wait2", 8'hA5, 1'b1, 32'h0, 32'hCAFEF00D, ^32'hCAFEF00D);

        g_acks = '{A_WAIT};
        xfer("wait_forever", 8'h8D, 1'b1, 32'h0, 32'h5A5A1234, 1'b0);

        g_acks = '{A_OK};
        xfer("write_81", 8'h81, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1);

        g_acks = '{A_OK};
        xfer("perr", 8'hA5, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1);

        g_acks = '{A_FAULT};
        xfer("fault", 8'hA5, 1'b1, 32'h0, 32'h13572468, 1'b0);

        g_acks = '{A_WAIT, A_NONE};
        xfer("noresp", 8'hB1, 1'b0, 32'h0F0F1234, 32'h0, 1'b0);

        // Reset in the middle of a read frame.
        accept("rst_mid", 8'hA5, 1'b1, 32'h0);
        for (int k = 0; k < 20; k++) begin
            i_fe_miso = 1'($urandom_range(0, 1));
            pulse_tick();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("rst_mid");
        bad = 1'b0;
        repeat (60) begin
            pulse_tick();
            if (o_rsp_valid !== 1'b0 || o_fe_rst_n !== 1'b0) bad = 1'b1;
        end
        chk("rst_mid:quiet", 64'(bad), 64'd0);
        g_acks = '{A_OK};
        xfer("after_rst", 8'hA5, 1'b1, 32'h0, 32'h87654321, ^32'h87654321);

        for (int i = 0; i < 6; i++) begin
            logic [2:0] fin;
            g_acks.delete();
            repeat ($urandom_range(0, 9)) g_acks.push_back(A_WAIT);
            case ($urandom_range(0, 3))
                0: fin = A_OK;
                1: fin = A_FAULT;
                2: fin = A_NONE;
                default: fin = 3'($urandom_range(0, 7));
            endcase
            g_acks.push_back(fin);
            d = $urandom;
            xfer($sformatf("rand%0d", i), 8'($urandom), 1'($urandom_range(0, 1)),
                 $urandom, d, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
